instr_decode: RTL and testbench

Instruction decode stage of the Risc-Inci pipeline, between fetch and execute. It accepts one fetched RV32I instruction per cycle over a valid/ready handshake and drives the register file read controls (`rs1Cntrl`, `rs2Cntrl`) in the same cycle. It registers the decoded fields, so they reach execute together with the register file read data one cycle later. It also detects load-use hazards against the instruction it holds, inserts one bubble when needed, and counts hazard stall cycles.

---
 rtl/instr_decode_if.sv | 42 ++++
 rtl/instr_decode.sv | 160 ++++++++++++++++
 tb/tb_instr_decode.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_if.sv
// Fetch/decode/execute bus of the instruction decode stage.
// The decode stage uses the slave modport; the fetch/execute side uses master.
interface instr_decode_if #(
   parameter int cDataWidth     = 32,
   parameter int cStallCntWidth = 16
);
   typedef struct packed {
      logic       en;
      logic [4:0] addr;
   } tRegControl;

   logic [31:0]               iInstr;
   logic [31:0]               iPc;
   logic                      iInstrValid;
   logic                      oInstrReady;
   logic                      iFlush;
   tRegControl                rs1Cntrl;
   tRegControl                rs2Cntrl;
   logic                      oDecValid;
   logic                      iExReady;
   logic [31:0]               oPc;
   logic [6:0]                oOpcode;
   logic [2:0]                oFunct3;
   logic [6:0]                oFunct7;
   logic [4:0]                oRdAddr;
   logic                      oRdWe;
   logic [cDataWidth-1:0]     oImm;
   logic                      oIllegal;
   logic [cStallCntWidth-1:0] oStallCnt;

   modport slave (
      input  iInstr, iPc, iInstrValid, iFlush, iExReady,
      output oInstrReady, rs1Cntrl, rs2Cntrl, oDecValid, oPc, oOpcode,
             oFunct3, oFunct7, oRdAddr, oRdWe, oImm, oIllegal, oStallCnt
   );

   modport master (
      output iInstr, iPc, iInstrValid, iFlush, iExReady,
      input  oInstrReady, rs1Cntrl, rs2Cntrl, oDecValid, oPc, oOpcode,
             oFunct3, oFunct7, oRdAddr, oRdWe, oImm, oIllegal, oStallCnt
   );
endinterface

// File: rtl/instr_decode.sv
// RV32I decode stage: register-file read controls in the accept cycle, registered
// decoded fields one cycle later, load-use bubble insertion and a stall counter.
module instr_decode #(
   parameter int cDataWidth     = 32,
   parameter int cStallCntWidth = 16
) (
   input logic           iClk,
   input logic           iRst,
   instr_decode_if.slave bus
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

   logic [31:0]        instr;
   fmt_e               fmt;
   logic signed [31:0] imm32;
   logic               rs1_use;
   logic               rs2_use;
   logic               rd_we;
   logic               hazard;
   logic               ready;
   logic               acc;

   logic                      dec_valid_q, dec_valid_d;
   logic [31:0]               pc_q, pc_d;
   logic [6:0]                opcode_q, opcode_d;
   logic [2:0]                funct3_q, funct3_d;
   logic [6:0]                funct7_q, funct7_d;
   logic [4:0]                rd_addr_q, rd_addr_d;
   logic                      rd_we_q, rd_we_d;
   logic [cDataWidth-1:0]     imm_q, imm_d;
   logic                      illegal_q, illegal_d;
   logic [cStallCntWidth-1:0] stall_cnt_q, stall_cnt_d;

   assign instr = bus.iInstr;

   // FENCE and SYSTEM are legal base opcodes and decode as I-type.
   always_comb begin
      fmt = FMT_BAD;
      case (instr[6:0])
         OP_OP:                                        fmt = FMT_R;
         OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: fmt = FMT_I;
         OP_STORE:                                     fmt = FMT_S;
         OP_BRANCH:                                    fmt = FMT_B;
         OP_LUI, OP_AUIPC:                             fmt = FMT_U;
         OP_JAL:                                       fmt = FMT_J;
         default:                                      fmt = FMT_BAD;
      endcase

      imm32 = '0;
      case (fmt)
         FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm32 = {instr[31:12], 12'b0};
         FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase

      rs1_use = bus.iInstrValid && (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B});
      rs2_use = bus.iInstrValid && (fmt inside {FMT_R, FMT_S, FMT_B});
      rd_we   = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (instr[11:7] != 5'd0);
   end

   // The hazard compares against the raw (pre-accept) enables to avoid a loop through ready.
   always_comb begin
      hazard = dec_valid_q && (opcode_q == OP_LOAD) && (rd_addr_q != 5'd0) &&
               ((rs1_use && (instr[19:15] == rd_addr_q)) ||
                (rs2_use && (instr[24:20] == rd_addr_q)));
      ready  = !iRst && !bus.iFlush && !hazard && (!dec_valid_q || bus.iExReady);
      acc    = bus.iInstrValid && ready;

      bus.oInstrReady   = ready;
      bus.rs1Cntrl.en   = rs1_use && acc;
      bus.rs1Cntrl.addr = (rs1_use && acc) ? instr[19:15] : 5'd0;
      bus.rs2Cntrl.en   = rs2_use && acc;
      bus.rs2Cntrl.addr = (rs2_use && acc) ? instr[24:20] : 5'd0;
   end

   always_comb begin
      dec_valid_d = dec_valid_q;
      pc_d        = pc_q;
      opcode_d    = opcode_q;
      funct3_d    = funct3_q;
      funct7_d    = funct7_q;
      rd_addr_d   = rd_addr_q;
      rd_we_d     = rd_we_q;
      imm_d       = imm_q;
      illegal_d   = illegal_q;
      stall_cnt_d = stall_cnt_q;

      if (bus.iFlush) begin
         dec_valid_d = 1'b0;
      end else if (acc) begin
         dec_valid_d = 1'b1;
         pc_d        = bus.iPc;
         opcode_d    = instr[6:0];
         funct3_d    = instr[14:12];
         funct7_d    = instr[31:25];
         rd_we_d     = rd_we;
         rd_addr_d   = rd_we ? instr[11:7] : 5'd0;
         imm_d       = cDataWidth'(imm32);
         illegal_d   = (fmt == FMT_BAD);
      end else if (dec_valid_q && bus.iExReady) begin
         dec_valid_d = 1'b0;
      end

      if (bus.iInstrValid && hazard && !bus.iFlush && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + cStallCntWidth'(1);
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         dec_valid_q <= 1'b0;
         pc_q        <= '0;
         opcode_q    <= '0;
         funct3_q    <= '0;
         funct7_q    <= '0;
         rd_addr_q   <= '0;
         rd_we_q     <= 1'b0;
         imm_q       <= '0;
         illegal_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         dec_valid_q <= dec_valid_d;
         pc_q        <= pc_d;
         opcode_q    <= opcode_d;
         funct3_q    <= funct3_d;
         funct7_q    <= funct7_d;
         rd_addr_q   <= rd_addr_d;
         rd_we_q     <= rd_we_d;
         imm_q       <= imm_d;
         illegal_q   <= illegal_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.oDecValid = dec_valid_q;
   assign bus.oPc       = pc_q;
   assign bus.oOpcode   = opcode_q;
   assign bus.oFunct3   = funct3_q;
   assign bus.oFunct7   = funct7_q;
   assign bus.oRdAddr   = rd_addr_q;
   assign bus.oRdWe     = rd_we_q;
   assign bus.oImm      = imm_q;
   assign bus.oIllegal  = illegal_q;
   assign bus.oStallCnt = stall_cnt_q;
endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: vector table, hand sequences, random traffic against a
// cycle model, plus a 2-bit counter instance for saturation.
module tb_instr_decode;
   logic clk = 1'b0;
   logic rst;
   logic rst_s;
   always #5 clk = ~clk;

   instr_decode_if #(.cDataWidth(32), .cStallCntWidth(16)) bus ();
   instr_decode_if #(.cDataWidth(32), .cStallCntWidth(2))  bus_s ();

   instr_decode #(.cDataWidth(32), .cStallCntWidth(16)) u_dut (
      .iClk(clk), .iRst(rst), .bus(bus)
   );
   instr_decode #(.cDataWidth(32), .cStallCntWidth(2)) u_sat (
      .iClk(clk), .iRst(rst_s), .bus(bus_s)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rs1_en;
      logic        rs2_en;
      logic        rd_we;
      logic        illegal;
      logic [4:0]  rd;
      logic [31:0] imm;
   } dec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
      logic [5:0]  rs1;
      logic [5:0]  rs2;
   } vec_t;

   // model of the output register
   logic        m_valid;
   logic [31:0] m_pc, m_imm;
   logic [6:0]  m_op, m_f7;
   logic [2:0]  m_f3;
   logic [4:0]  m_rd;
   logic        m_we, m_ill;
   int unsigned m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference decode computed from field arithmetic on the instruction word.
   function automatic dec_t ref_decode(input logic [31:0] ins);
      dec_t    d;
      byte     kind;
      int      sgn;
      int      v;
      case (ins[6:0])
         7'h33:                         kind = "R";
         7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: kind = "I";
         7'h23:                         kind = "S";
         7'h63:                         kind = "B";
         7'h37, 7'h17:                  kind = "U";
         7'h6F:                         kind = "J";
         default:                       kind = "X";
      endcase
      sgn = int'(ins[31]);
      v = 0;
      case (kind)
         "I": v = int'(ins[31:20]) - sgn * 4096;
         "S": v = int'(ins[31:25]) * 32 + int'(ins[11:7]) - sgn * 4096;
         "B": v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - sgn * 4096;
         "U": v = int'(ins[31:12]) * 4096;
         "J": v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                  - sgn * 1048576;
         default: v = 0;
      endcase
      d.imm     = v;
      d.illegal = (kind == "X");
      d.rs1_en  = (kind == "R") || (kind == "I") || (kind == "S") || (kind == "B");
      d.rs2_en  = (kind == "R") || (kind == "S") || (kind == "B");
      d.rd_we   = ((kind == "R") || (kind == "I") || (kind == "U") || (kind == "J"))
                  && (ins[11:7] != 5'd0);
      d.rd      = d.rd_we ? ins[11:7] : 5'd0;
      return d;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_pc = 0; m_imm = 0; m_op = 0; m_f7 = 0; m_f3 = 0;
      m_rd = 0; m_we = 0; m_ill = 0; m_cnt = 0;
   endtask

   // One clock cycle on the main DUT: drive, check against the model, advance the model.
   task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                       input logic fl, input logic exr, input logic r);
      dec_t d;
      logic hz, rdy, acc;
      @(negedge clk);
      rst = r;
      bus.iInstr = ins; bus.iPc = pc; bus.iInstrValid = v;
      bus.iFlush = fl; bus.iExReady = exr;
      #1;
      d   = ref_decode(ins);
      hz  = m_valid && (m_op == 7'h03) && (m_rd != 0) && v &&
            ((d.rs1_en && ins[19:15] == m_rd) || (d.rs2_en && ins[24:20] == m_rd));
      rdy = !r && !fl && !hz && (!m_valid || exr);
      acc = v && rdy;
      chk("ready", bus.oInstrReady, rdy);
      chk("rs1", {bus.rs1Cntrl.en, bus.rs1Cntrl.addr}, (acc && d.rs1_en) ? {1'b1, ins[19:15]} : 6'h00);
      chk("rs2", {bus.rs2Cntrl.en, bus.rs2Cntrl.addr}, (acc && d.rs2_en) ? {1'b1, ins[24:20]} : 6'h00);
      chk("dec_valid", bus.oDecValid, m_valid);
      chk("pc", bus.oPc, m_pc);
      chk("opcode", bus.oOpcode, m_op);
      chk("funct3", bus.oFunct3, m_f3);
      chk("funct7", bus.oFunct7, m_f7);
      chk("rd_addr", bus.oRdAddr, m_rd);
      chk("rd_we", bus.oRdWe, m_we);
      chk("imm", bus.oImm, m_imm);
      chk("illegal", bus.oIllegal, m_ill);
      chk("stall_cnt", bus.oStallCnt, m_cnt[15:0]);
      if (r) begin
         model_clear();
      end else begin
         if (v && hz && !fl && m_cnt < 65535) m_cnt++;
         if (fl) begin
            m_valid = 0;
         end else if (acc) begin
            m_valid = 1; m_pc = pc; m_op = ins[6:0]; m_f3 = ins[14:12]; m_f7 = ins[31:25];
            m_rd = d.rd; m_we = d.rd_we; m_imm = d.imm; m_ill = d.illegal;
            $display("XACT pc=%08h instr=%08h imm=%08h rd=%0d we=%0d ill=%0d",
                     pc, ins, d.imm, d.rd, d.rd_we, d.illegal);
         end else if (m_valid && exr) begin
            m_valid = 0;
         end
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  op;
      w = $urandom;
      case ($urandom_range(0, 13))
         0, 1:    op = 7'h03;
         2:       op = 7'h33;
         3:       op = 7'h13;
         4:       op = 7'h23;
         5:       op = 7'h63;
         6:       op = 7'h37;
         7:       op = 7'h17;
         8:       op = 7'h6F;
         9:       op = 7'h67;
         10:      op = 7'h0F;
         11:      op = 7'h73;
         12:      op = 7'h7F;
         default: op = 7'h0B;
      endcase
      w[6:0]   = op;
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   initial begin
      vec_t vecs [10];
      logic [31:0] rpc;

      vecs[0] = '{32'h00500093, 32'h00000005, 5'd1, 1'b1, 1'b0, 6'h20, 6'h00};
      vecs[1] = '{32'hFE208EE3, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0, 6'h21, 6'h22};
      vecs[2] = '{32'h123452B7, 32'h12345000, 5'd5, 1'b1, 1'b0, 6'h00, 6'h00};
      vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 5'd0, 1'b0, 1'b1, 6'h00, 6'h00};
      vecs[4] = '{32'h0020A423, 32'h00000008, 5'd0, 1'b0, 1'b0, 6'h21, 6'h22};
      vecs[5] = '{32'h001000EF, 32'h00000800, 5'd1, 1'b1, 1'b0, 6'h00, 6'h00};
      vecs[6] = '{32'h0000A103, 32'h00000000, 5'd2, 1'b1, 1'b0, 6'h21, 6'h00};
      vecs[7] = '{32'h00110033, 32'h00000000, 5'd0, 1'b0, 1'b0, 6'h22, 6'h21};
      vecs[8] = '{32'hFFF00093, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0, 6'h20, 6'h00};
      vecs[9] = '{32'hFFFFF397, 32'hFFFFF000, 5'd7, 1'b1, 1'b0, 6'h00, 6'h00};

      rst = 1; rst_s = 1;
      bus.iInstr = 0; bus.iPc = 0; bus.iInstrValid = 0; bus.iFlush = 0; bus.iExReady = 0;
      bus_s.iInstr = 0; bus_s.iPc = 0; bus_s.iInstrValid = 0; bus_s.iFlush = 0; bus_s.iExReady = 0;
      repeat (2) @(posedge clk);
      model_clear();

      // reset state, with an instruction offered during reset
      step(32'h00500093, 32'h0, 1, 0, 1, 1);
      step(32'h0, 32'h0, 0, 0, 1, 0);

      // addi
      step(32'h00500093, 32'h100, 1, 0, 1, 0);
      chk("addi_rs1", {bus.rs1Cntrl.en, bus.rs1Cntrl.addr}, 6'h20);
      chk("addi_rs2", {bus.rs2Cntrl.en, bus.rs2Cntrl.addr}, 6'h00);
      step(32'h0, 32'h0, 0, 0, 1, 0);
      chk("addi_imm", bus.oImm, 32'd5);
      chk("addi_rd", bus.oRdAddr, 5'd1);
      chk("addi_we", bus.oRdWe, 1'b1);

      // load-use
      step(32'h0000A103, 32'h200, 1, 0, 1, 0);
      step(32'h001101B3, 32'h204, 1, 0, 1, 0);
      chk("lu_ready_low", bus.oInstrReady, 1'b0);
      step(32'h001101B3, 32'h204, 1, 0, 1, 0);
      chk("lu_bubble", bus.oDecValid, 1'b0);
      chk("lu_ready_high", bus.oInstrReady, 1'b1);
      chk("lu_add_rs1", {bus.rs1Cntrl.en, bus.rs1Cntrl.addr}, 6'h22);
      chk("lu_add_rs2", {bus.rs2Cntrl.en, bus.rs2Cntrl.addr}, 6'h21);
      step(32'h0, 32'h0, 0, 0, 1, 0);
      chk("lu_add_held", bus.oDecValid, 1'b1);
      chk("lu_add_rd", bus.oRdAddr, 5'd3);
      chk("lu_stall_cnt", bus.oStallCnt, 16'd1);

      // vector table
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].instr, 32'h300 + 32'(i * 4), 1, 0, 1, 0);
         chk("vec_rs1", {bus.rs1Cntrl.en, bus.rs1Cntrl.addr}, vecs[i].rs1);
         chk("vec_rs2", {bus.rs2Cntrl.en, bus.rs2Cntrl.addr}, vecs[i].rs2);
         step(32'h0, 32'h0, 0, 0, 1, 0);
         chk("vec_imm", bus.oImm, vecs[i].imm);
         chk("vec_rd", bus.oRdAddr, vecs[i].rd);
         chk("vec_we", bus.oRdWe, vecs[i].we);
         chk("vec_ill", bus.oIllegal, vecs[i].ill);
      end

      // back-pressure then flush
      step(32'h00500093, 32'h400, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(32'h00208133, 32'h404, 1, 0, 0, 0);
         chk("bp_ready", bus.oInstrReady, 1'b0);
         chk("bp_valid", bus.oDecValid, 1'b1);
         chk("bp_imm", bus.oImm, 32'd5);
         chk("bp_rd", bus.oRdAddr, 5'd1);
         chk("bp_cnt", bus.oStallCnt, 16'd1);
      end
      step(32'h00208133, 32'h404, 1, 1, 0, 0);
      chk("flush_ready", bus.oInstrReady, 1'b0);
      step(32'h0, 32'h0, 0, 0, 0, 0);
      chk("flush_valid", bus.oDecValid, 1'b0);

      // random traffic
      rpc = 32'h1000;
      for (int i = 0; i < 400; i++) begin
         step(rand_instr(), rpc, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) < 7), 0);
         if (bus.oInstrReady && bus.iInstrValid) rpc = rpc + 4;
      end

      // reset mid-operation
      step(32'h00500093, 32'h500, 1, 0, 1, 0);
      step(32'h00600113, 32'h504, 1, 0, 0, 1);
      chk("rst_held_before", bus.oDecValid, 1'b1);
      chk("rst_ready", bus.oInstrReady, 1'b0);
      step(32'h00600113, 32'h504, 1, 0, 1, 0);
      chk("rst_valid", bus.oDecValid, 1'b0);
      chk("rst_imm", bus.oImm, 32'd0);
      chk("rst_pc", bus.oPc, 32'd0);
      chk("rst_first_accept", bus.oInstrReady, 1'b1);
      step(32'h0, 32'h0, 0, 0, 1, 0);

      // counter saturation on the 2-bit instance
      @(negedge clk);
      rst_s = 0;
      bus_s.iInstr = 32'h0000A103; bus_s.iPc = 32'h0; bus_s.iInstrValid = 1; bus_s.iExReady = 1;
      @(negedge clk);
      bus_s.iInstr = 32'h001101B3; bus_s.iExReady = 0;
      #1;
      chk("sat_start", bus_s.oStallCnt, 2'd0);
      chk("sat_ready", bus_s.oInstrReady, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         #1;
         chk("sat_cnt", bus_s.oStallCnt, (k < 3) ? k : 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
